// File: rtl/ltsm_sb_pkg.sv
// Shared LTSM sideband definitions: D2C point-test message codes and engine state encoding.
package ltsm_sb_pkg;

  localparam int unsigned SB_CODE_W = 4;

  localparam logic [SB_CODE_W-1:0] SB_NONE          = 4'd0;
  localparam logic [SB_CODE_W-1:0] SB_START_REQ     = 4'd1;
  localparam logic [SB_CODE_W-1:0] SB_START_RESP    = 4'd2;
  localparam logic [SB_CODE_W-1:0] SB_LFSR_CLR_REQ  = 4'd3;
  localparam logic [SB_CODE_W-1:0] SB_LFSR_CLR_RESP = 4'd4;
  localparam logic [SB_CODE_W-1:0] SB_RESULT_REQ    = 4'd5;
  localparam logic [SB_CODE_W-1:0] SB_RESULT_RESP   = 4'd6;
  localparam logic [SB_CODE_W-1:0] SB_END_REQ       = 4'd7;
  localparam logic [SB_CODE_W-1:0] SB_END_RESP      = 4'd8;

  typedef enum logic [2:0] {
    PT_IDLE     = 3'd0,
    PT_START    = 3'd1,
    PT_LFSR_CLR = 3'd2,
    PT_BURST    = 3'd3,
    PT_RESULT   = 3'd4,
    PT_END      = 3'd5,
    PT_DONE     = 3'd6
  } pt_state_e;

  // Counter width that stays legal for a single-cycle burst.
  function automatic int unsigned burst_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/point_test_burst_cnt.sv
// Loadable down-counter timing the mainband pattern burst; saturates at zero.
module point_test_burst_cnt #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tx_d2c_point_test.sv
// Tx-initiated D2C point-test engine: sideband start/LFSR-clear/result/end handshakes around a
// fixed-length mainband pattern burst. All outputs are registered.
module tx_d2c_point_test
  import ltsm_sb_pkg::*;
#(
  parameter int unsigned LANES        = 16,
  parameter int unsigned SB_MSG_W     = 4,
  parameter int unsigned BURST_CYCLES = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_valtrain_sel,
  input  logic                i_lfsr_or_perlane,
  input  logic [SB_MSG_W-1:0] i_sideband_message,
  input  logic                i_sideband_valid,
  input  logic [LANES-1:0]    i_sideband_data,
  input  logic                i_busy_negedge_detected,
  output logic [SB_MSG_W-1:0] o_sideband_message,
  output logic                o_valid_tx,
  output logic                o_pattern_en,
  output logic                o_pattern_type,
  output logic                o_valtrain_sel,
  output logic                o_lfsr_clear,
  output logic [LANES-1:0]    o_lanes_result,
  output logic                o_valid_framing_error,
  output logic                o_test_ack,
  output logic [2:0]          o_dbg_state
);

  localparam int unsigned CNT_W = burst_cnt_w(BURST_CYCLES);
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_CYCLES - 1);

  // Handshake: o_valid_tx rises with each message load and falls when the sideband tx reports
  // acceptance via i_busy_negedge_detected; a load in the same cycle as acceptance keeps it high.
  // Partner responses are taken only when i_sideband_valid=1, independent of o_valid_tx.

  pt_state_e           state_q, state_d;
  logic [SB_MSG_W-1:0] msg_q, msg_d;
  logic                valid_q, valid_d;
  logic                pat_en_q, pat_en_d;
  logic                pat_type_q, pat_type_d;
  logic                vsel_q, vsel_d;
  logic                lfsr_clr_q, lfsr_clr_d;
  logic [LANES-1:0]    lanes_q, lanes_d;
  logic                fe_q, fe_d;
  logic                ack_q, ack_d;

  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]    cnt_val;

  logic rx_start_resp, rx_lfsr_resp, rx_result_resp, rx_end_resp;

  assign rx_start_resp  = i_sideband_valid && (i_sideband_message == SB_MSG_W'(SB_START_RESP));
  assign rx_lfsr_resp   = i_sideband_valid && (i_sideband_message == SB_MSG_W'(SB_LFSR_CLR_RESP));
  assign rx_result_resp = i_sideband_valid && (i_sideband_message == SB_MSG_W'(SB_RESULT_RESP));
  assign rx_end_resp    = i_sideband_valid && (i_sideband_message == SB_MSG_W'(SB_END_RESP));

  point_test_burst_cnt #(
    .W(CNT_W)
  ) u_burst_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .dec_i     (cnt_dec),
    .load_val_i(BURST_LOAD),
    .cnt_o     (cnt_val),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    valid_d    = valid_q & ~i_busy_negedge_detected;
    pat_en_d   = pat_en_q;
    pat_type_d = pat_type_q;
    vsel_d     = vsel_q;
    lfsr_clr_d = 1'b0;
    lanes_d    = lanes_q;
    fe_d       = fe_q;
    ack_d      = ack_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    if (!i_en) begin
      // Abort from any state; results stay visible until the next RESULT_RESP.
      state_d  = PT_IDLE;
      msg_d    = '0;
      valid_d  = 1'b0;
      pat_en_d = 1'b0;
      ack_d    = 1'b0;
    end else begin
      unique case (state_q)
        PT_IDLE: begin
          state_d    = PT_START;
          msg_d      = SB_MSG_W'(SB_START_REQ);
          valid_d    = 1'b1;
          pat_type_d = i_lfsr_or_perlane;
          vsel_d     = i_valtrain_sel;
        end
        PT_START: begin
          if (rx_start_resp) begin
            state_d    = PT_LFSR_CLR;
            msg_d      = SB_MSG_W'(SB_LFSR_CLR_REQ);
            valid_d    = 1'b1;
            lfsr_clr_d = 1'b1;
          end
        end
        PT_LFSR_CLR: begin
          if (rx_lfsr_resp) begin
            state_d  = PT_BURST;
            pat_en_d = 1'b1;
            cnt_load = 1'b1;
          end
        end
        PT_BURST: begin
          if (cnt_zero) begin
            state_d  = PT_RESULT;
            pat_en_d = 1'b0;
            msg_d    = SB_MSG_W'(SB_RESULT_REQ);
            valid_d  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        PT_RESULT: begin
          if (rx_result_resp) begin
            state_d = PT_END;
            msg_d   = SB_MSG_W'(SB_END_REQ);
            valid_d = 1'b1;
            // A valid-lane test reports only the framing bit; lanes are forced to pass.
            if (vsel_q) begin
              lanes_d = '1;
              fe_d    = ~i_sideband_data[0];
            end else begin
              lanes_d = i_sideband_data;
              fe_d    = 1'b0;
            end
          end
        end
        PT_END: begin
          if (rx_end_resp) begin
            state_d = PT_DONE;
            ack_d   = 1'b1;
          end
        end
        PT_DONE: begin
          ack_d = 1'b1;
        end
        default: begin
          state_d = PT_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PT_IDLE;
      msg_q      <= '0;
      valid_q    <= 1'b0;
      pat_en_q   <= 1'b0;
      pat_type_q <= 1'b0;
      vsel_q     <= 1'b0;
      lfsr_clr_q <= 1'b0;
      lanes_q    <= '0;
      fe_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      valid_q    <= valid_d;
      pat_en_q   <= pat_en_d;
      pat_type_q <= pat_type_d;
      vsel_q     <= vsel_d;
      lfsr_clr_q <= lfsr_clr_d;
      lanes_q    <= lanes_d;
      fe_q       <= fe_d;
      ack_q      <= ack_d;
    end
  end

  assign o_sideband_message    = msg_q;
  assign o_valid_tx            = valid_q;
  assign o_pattern_en          = pat_en_q;
  assign o_pattern_type        = pat_type_q;
  assign o_valtrain_sel        = vsel_q;
  assign o_lfsr_clear          = lfsr_clr_q;
  assign o_lanes_result        = lanes_q;
  assign o_valid_framing_error = fe_q;
  assign o_test_ack            = ack_q;
  assign o_dbg_state           = state_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule
